// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and helpers for the elastic pipeline register (pipe_stage_reg).
// Imported by the interface and the top level.
package pipe_pkg;

  localparam int PIPE_MAX_STAGES = 8;
  localparam int PIPE_CNT_W      = 32;

  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle for pipe_stage_reg; the slave modport is the register
// chain itself, the master modport is the surrounding pipeline.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int TAG_W  = 5,
  parameter int STAGES = 1
);

  localparam int OCC_W = occ_width(STAGES);

  logic              valid_i;
  logic              ready_o;
  logic [CTRL_W-1:0] ctrl_i;
  logic [TAG_W-1:0]  tag_i;
  logic [DATA_W-1:0] data_i;
  logic              cpu_stall_i;
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  logic [CTRL_W-1:0] ctrl_o;
  logic [TAG_W-1:0]  tag_o;
  logic [DATA_W-1:0] data_o;
  logic [OCC_W-1:0]  occ_o;

  modport slave (
    input  valid_i, ctrl_i, tag_i, data_i, cpu_stall_i, flush_i, ready_i,
    output ready_o, valid_o, ctrl_o, tag_o, data_o, occ_o
  );

  modport master (
    output valid_i, ctrl_i, tag_i, data_i, cpu_stall_i, flush_i, ready_i,
    input  ready_o, valid_o, ctrl_o, tag_o, data_o, occ_o
  );

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One slot of the elastic chain: valid/ctrl/tag/data registers with load, drain and flush.
// Flush kills the entry and its control bits but leaves tag/data untouched.
module pipe_slot #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic              flush,
  input  logic [CTRL_W-1:0] nxt_ctrl,
  input  logic [TAG_W-1:0]  nxt_tag,
  input  logic [DATA_W-1:0] nxt_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      tag   <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else begin
      valid <= load | (valid & ~drain);
      if (load) begin
        ctrl <= nxt_ctrl;
        tag  <= nxt_tag;
        data <= nxt_data;
      end
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised elastic pipeline register: STAGES slots, bubble collapse, global stall, flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int TAG_W  = 5,
  parameter int STAGES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipe_stage_reg_if.slave       bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PIPE_CNT_W-1:0] stall_cnt_o,
  output logic [PIPE_CNT_W-1:0] bubble_cnt_o
`endif
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic              ready;
  logic              accept;
  logic [OCC_W-1:0]  occ;

  logic [CTRL_W-1:0] ctrl_q   [STAGES];
  logic [TAG_W-1:0]  tag_q    [STAGES];
  logic [DATA_W-1:0] data_q   [STAGES];
  logic [CTRL_W-1:0] nxt_ctrl [STAGES];
  logic [TAG_W-1:0]  nxt_tag  [STAGES];
  logic [DATA_W-1:0] nxt_data [STAGES];

  // A slot advances when it is valid and the slot ahead is empty or itself advancing;
  // evaluated from the head backwards so the whole chain can move in one cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = v[STAGES-1] & bus.ready_i & ~bus.cpu_stall_i;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = v[k] & (~v[k+1] | adv[k+1]) & ~bus.cpu_stall_i;
    end
  end

  assign ready  = ~bus.cpu_stall_i & ~bus.flush_i & (~v[0] | adv[0]);
  assign accept = bus.valid_i & ready;

  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    if (g == 0) begin : g_src_in
      assign nxt_ctrl[g] = bus.ctrl_i;
      assign nxt_tag[g]  = bus.tag_i;
      assign nxt_data[g] = bus.data_i;
    end else begin : g_src_prev
      assign nxt_ctrl[g] = ctrl_q[g-1];
      assign nxt_tag[g]  = tag_q[g-1];
      assign nxt_data[g] = data_q[g-1];
    end

    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W),
      .TAG_W  (TAG_W)
    ) u_slot (
      .clk      (clk_i),
      .rst      (rst_i),
      .load     (load[g]),
      .drain    (adv[g]),
      .flush    (bus.flush_i),
      .nxt_ctrl (nxt_ctrl[g]),
      .nxt_tag  (nxt_tag[g]),
      .nxt_data (nxt_data[g]),
      .valid    (v[g]),
      .ctrl     (ctrl_q[g]),
      .tag      (tag_q[g]),
      .data     (data_q[g])
    );
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(v[k]);
    end
  end

  // Control bits are masked when the head is empty so no stale enable escapes.
  assign bus.ready_o = ready;
  assign bus.valid_o = v[STAGES-1];
  assign bus.ctrl_o  = v[STAGES-1] ? ctrl_q[STAGES-1] : '0;
  assign bus.tag_o   = tag_q[STAGES-1];
  assign bus.data_o  = data_q[STAGES-1];
  assign bus.occ_o   = occ;

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (bus.cpu_stall_i && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (!v[STAGES-1] && !bus.cpu_stall_i && (bubble_cnt_o != '1)) begin
        bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// against a queue-of-entries reference model (STAGES=3), and a STAGES=2 reset scenario.
module tb_pipe_stage_reg;

  localparam int S3 = 3;

  logic clk = 1'b0;
  logic rst2;
  logic rst3;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(2), .TAG_W(5), .STAGES(2))  b2 ();
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(2), .TAG_W(5), .STAGES(S3)) b3 ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt2, bubble_cnt2, stall_cnt3, bubble_cnt3;
`endif

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(2), .TAG_W(5), .STAGES(2)) u_dut2 (
    .clk_i (clk),
    .rst_i (rst2),
    .bus   (b2)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt2),
    .bubble_cnt_o (bubble_cnt2)
`endif
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(2), .TAG_W(5), .STAGES(S3)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst3),
    .bus   (b3)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt3),
    .bubble_cnt_o (bubble_cnt3)
`endif
  );

  // Reference model: in-flight entries, head first, each tagged with its slot position.
  typedef struct {
    int          pos;
    logic [1:0]  ctrl;
    logic [4:0]  tag;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  bit          mv [8];
  bit          exp_head_v;
  bit          exp_ready;
  logic [31:0] exp_stall_cnt;
  logic [31:0] exp_bubble_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input logic ri, input logic st, input logic fl);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      if (st) mv[i] = 1'b0;
      else if (i == 0) mv[i] = (q[0].pos == S3 - 1) ? ri : 1'b1;
      else mv[i] = (q[i].pos + 1 != q[i-1].pos) || mv[i-1];
    end
    exp_head_v = (n > 0) && (q[0].pos == S3 - 1);
    exp_ready  = !st && !fl && ((n == 0) || (q[n-1].pos != 0) || mv[n-1]);
    chk("valid_o", 64'(b3.valid_o), 64'(exp_head_v));
    chk("ctrl_o", 64'(b3.ctrl_o), exp_head_v ? 64'(q[0].ctrl) : 64'd0);
    if (exp_head_v) begin
      chk("tag_o", 64'(b3.tag_o), 64'(q[0].tag));
      chk("data_o", b3.data_o, q[0].data);
    end
    chk("occ_o", 64'(b3.occ_o), 64'(n));
    chk("ready_o", 64'(b3.ready_o), 64'(exp_ready));
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 64'(stall_cnt3), 64'(exp_stall_cnt));
    chk("bubble_cnt", 64'(bubble_cnt3), 64'(exp_bubble_cnt));
`endif
  endtask

  task automatic model_advance(input logic vi, input logic [1:0] c, input logic [4:0] t,
                               input logic [63:0] d, input logic st, input logic fl);
    ent_t nq[$];
    ent_t e;
    if (st && exp_stall_cnt != '1) exp_stall_cnt++;
    if (!exp_head_v && !st && exp_bubble_cnt != '1) exp_bubble_cnt++;
    if (fl) begin
      q.delete();
    end else if (!st) begin
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        if (mv[i]) begin
          if (e.pos == S3 - 1) continue;
          e.pos++;
        end
        nq.push_back(e);
      end
      q = nq;
    end
    if (vi && exp_ready) q.push_back('{0, c, t, d});
  endtask

  task automatic apply_stimulus(input logic vi, input logic [1:0] c, input logic [4:0] t,
                                input logic [63:0] d, input logic ri, input logic st,
                                input logic fl);
    b3.valid_i     = vi;
    b3.ctrl_i      = c;
    b3.tag_i       = t;
    b3.data_i      = d;
    b3.ready_i     = ri;
    b3.cpu_stall_i = st;
    b3.flush_i     = fl;
    #1;
    check_output(ri, st, fl);
    model_advance(vi, c, t, d, st, fl);
    @(negedge clk);
  endtask

  task automatic reset3();
    b3.valid_i = 0; b3.ctrl_i = 0; b3.tag_i = 0; b3.data_i = 0;
    b3.ready_i = 0; b3.cpu_stall_i = 0; b3.flush_i = 0;
    rst3 = 1'b1;
    #1;
    chk("rst3_valid", 64'(b3.valid_o), 64'd0);
    chk("rst3_occ", 64'(b3.occ_o), 64'd0);
    rst3 = 1'b0;
    q.delete();
    exp_stall_cnt  = '0;
    exp_bubble_cnt = '0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst2 = 1'b1;
    rst3 = 1'b1;
    b2.valid_i = 0; b2.ctrl_i = 0; b2.tag_i = 0; b2.data_i = 0;
    b2.ready_i = 0; b2.cpu_stall_i = 0; b2.flush_i = 0;
    b3.valid_i = 0; b3.ctrl_i = 0; b3.tag_i = 0; b3.data_i = 0;
    b3.ready_i = 0; b3.cpu_stall_i = 0; b3.flush_i = 0;
    exp_stall_cnt  = '0;
    exp_bubble_cnt = '0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] reset values");
    chk("reset_valid", 64'(b3.valid_o), 64'd0);
    chk("reset_ctrl", 64'(b3.ctrl_o), 64'd0);
    chk("reset_tag", 64'(b3.tag_o), 64'd0);
    chk("reset_data", b3.data_o, 64'd0);
    chk("reset_occ", 64'(b3.occ_o), 64'd0);
    chk("reset_ready", 64'(b3.ready_o), 64'd1);
    rst2 = 1'b0;
    rst3 = 1'b0;

    $display("[TB] STAGES=2 reset mid-stream");
    b2.valid_i = 1; b2.ctrl_i = 2'b11; b2.tag_i = 5'd1; b2.data_i = 64'd11;
    @(negedge clk);
    b2.tag_i = 5'd2; b2.data_i = 64'd12;
    @(negedge clk);
    b2.valid_i = 0;
    #1;
    chk("s2_occ_before", 64'(b2.occ_o), 64'd2);
    chk("s2_head_data", b2.data_o, 64'd11);
    chk("s2_head_ctrl", 64'(b2.ctrl_o), 64'd3);
    #1;
    rst2 = 1'b1;
    #1;
    chk("s2_rst_valid", 64'(b2.valid_o), 64'd0);
    chk("s2_rst_ctrl", 64'(b2.ctrl_o), 64'd0);
    chk("s2_rst_occ", 64'(b2.occ_o), 64'd0);
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("s2_ready_after", 64'(b2.ready_o), 64'd1);
    @(negedge clk);

    $display("[TB] streaming latency");
    reset3();
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(1'b1, 2'b01, 5'(i), 64'(i), 1'b1, 1'b0, 1'b0);
      if (i == 3) chk("lat_first", b3.data_o, 64'd1);
      if (i == 4) chk("lat_second", b3.data_o, 64'd2);
    end
    apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("lat_third", b3.data_o, 64'd3);
    apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("lat_fourth", b3.data_o, 64'd4);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0);

    $display("[TB] backpressure and bubble collapse");
    reset3();
    apply_stimulus(1'b1, 2'b11, 5'd10, 64'hA, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b11, 5'd11, 64'hB, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_occ2", 64'(b3.occ_o), 64'd2);
    chk("bp_ready_open", 64'(b3.ready_o), 64'd1);
    apply_stimulus(1'b1, 2'b11, 5'd12, 64'hC, 1'b0, 1'b0, 1'b0);
    chk("bp_occ_full", 64'(b3.occ_o), 64'd3);
    b3.valid_i = 1'b1;
    #1;
    chk("bp_ready_full", 64'(b3.ready_o), 64'd0);

    $display("[TB] stall then flush under stall");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 2'b11, 5'd13, 64'hD, 1'b1, 1'b1, 1'b0);
      chk("stall_data", b3.data_o, 64'hA);
      chk("stall_ctrl", 64'(b3.ctrl_o), 64'd3);
      chk("stall_occ", 64'(b3.occ_o), 64'd3);
    end
    apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b1, 1'b1);
    chk("flush_valid", 64'(b3.valid_o), 64'd0);
    chk("flush_ctrl", 64'(b3.ctrl_o), 64'd0);
    chk("flush_occ", 64'(b3.occ_o), 64'd0);
    chk("flush_data_hold", b3.data_o, 64'hA);

    $display("[TB] flush with offered input");
    apply_stimulus(1'b1, 2'b11, 5'd14, 64'hE, 1'b1, 1'b0, 1'b1);
    chk("flush_in_occ", 64'(b3.occ_o), 64'd0);

    $display("[TB] full chain with ready_i");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 2'b10, 5'(20 + i), 64'(100 + i), 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b10, 5'd23, 64'd103, 1'b1, 1'b0, 1'b0);
    chk("full_swap_occ", 64'(b3.occ_o), 64'd3);
    chk("full_swap_head", b3.data_o, 64'd101);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom),
                     {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 24) == 0));
    end

`ifdef PIPE_STAGE_PERF_EN
    $display("[TB] performance counters");
    reset3();
    chk("perf_rst_stall", 64'(stall_cnt3), 64'd0);
    chk("perf_rst_bubble", 64'(bubble_cnt3), 64'd0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("perf_stall5", 64'(stall_cnt3), 64'd5);
    chk("perf_bubble3", 64'(bubble_cnt3), 64'd3);
    force u_dut3.stall_cnt_o  = 32'hFFFF_FFFF;
    force u_dut3.bubble_cnt_o = 32'hFFFF_FFFF;
    #1;
    release u_dut3.stall_cnt_o;
    release u_dut3.bubble_cnt_o;
    exp_stall_cnt  = 32'hFFFF_FFFF;
    exp_bubble_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 2'b00, 5'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    chk("perf_sat_stall", 64'(stall_cnt3), 64'hFFFF_FFFF);
    chk("perf_sat_bubble", 64'(bubble_cnt3), 64'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
